// File: rtl/cache_miss_handler.sv
// rtl/cache_miss_handler.sv - cache miss/refill controller driving LRU updates; optional counters under MISS_HANDLER_STATS_EN
module cache_miss_handler #(
    parameter int NUM_WAYS_LOG2 = 2,
    parameter int INDEX_WIDTH   = 12,
    parameter int TAG_WIDTH     = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             miss_valid_i,
    output logic                             miss_ready_o,
    input  logic [INDEX_WIDTH-1:0]           miss_index_i,
    input  logic [TAG_WIDTH-1:0]             miss_tag_i,
    input  logic                             hit_i,
    input  logic [INDEX_WIDTH-1:0]           hit_index_i,
    input  logic [NUM_WAYS_LOG2-1:0]         hit_way_i,
    output logic [INDEX_WIDTH-1:0]           lru_index_o,
    output logic                             lru_write_en_o,
    output logic [NUM_WAYS_LOG2-1:0]         lru_set_o,
    input  logic [NUM_WAYS_LOG2-1:0]         lru_victim_i,
    output logic [NUM_WAYS_LOG2-1:0]         tag_rd_way_o,
    input  logic                             victim_valid_i,
    input  logic                             victim_dirty_i,
    input  logic [TAG_WIDTH-1:0]             victim_tag_i,
    output logic                             mem_req_o,
    output logic                             mem_we_o,
    output logic [TAG_WIDTH+INDEX_WIDTH-1:0] mem_addr_o,
    input  logic                             mem_ack_i,
    output logic                             tag_we_o,
    output logic [TAG_WIDTH-1:0]             tag_o,
    output logic                             fill_done_o,
    output logic [NUM_WAYS_LOG2-1:0]         fill_way_o
`ifdef MISS_HANDLER_STATS_EN
    ,
    output logic [15:0]                      miss_count_o,
    output logic [15:0]                      wb_count_o
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_LRU_RD, S_TAG_RD, S_WB, S_FILL, S_UPDATE, S_DONE
    } state_e;

    state_e                     state_q, state_d;
    logic [INDEX_WIDTH-1:0]     index_q, index_d;
    logic [TAG_WIDTH-1:0]       tag_q, tag_d;
    logic [NUM_WAYS_LOG2-1:0]   victim_q, victim_d;
    logic [TAG_WIDTH-1:0]       victim_tag_q, victim_tag_d;
    logic                       miss_accept;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            index_q      <= '0;
            tag_q        <= '0;
            victim_q     <= '0;
            victim_tag_q <= '0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            tag_q        <= tag_d;
            victim_q     <= victim_d;
            victim_tag_q <= victim_tag_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        index_d        = index_q;
        tag_d          = tag_q;
        victim_d       = victim_q;
        victim_tag_d   = victim_tag_q;
        miss_accept    = 1'b0;
        miss_ready_o   = 1'b0;
        lru_index_o    = '0;
        lru_write_en_o = 1'b0;
        lru_set_o      = '0;
        tag_rd_way_o   = '0;
        mem_req_o      = 1'b0;
        mem_we_o       = 1'b0;
        mem_addr_o     = '0;
        tag_we_o       = 1'b0;
        tag_o          = '0;
        fill_done_o    = 1'b0;
        fill_way_o     = '0;
        case (state_q)
            S_IDLE: begin
                miss_ready_o = !hit_i;
                if (hit_i) begin
                    lru_index_o    = hit_index_i;
                    lru_set_o      = hit_way_i;
                    lru_write_en_o = 1'b1;
                end else if (miss_valid_i) begin
                    // Present the index in the accept cycle so the LRU victim is ready during LRU_RD
                    lru_index_o = miss_index_i;
                    miss_accept = 1'b1;
                    index_d     = miss_index_i;
                    tag_d       = miss_tag_i;
                    state_d     = S_LRU_RD;
                end
            end
            S_LRU_RD: begin
                lru_index_o = index_q;
                victim_d    = lru_victim_i;
                state_d     = S_TAG_RD;
            end
            S_TAG_RD: begin
                lru_index_o  = index_q;
                tag_rd_way_o = victim_q;
                victim_tag_d = victim_tag_i;
                state_d      = (victim_valid_i && victim_dirty_i) ? S_WB : S_FILL;
            end
            S_WB: begin
                lru_index_o = index_q;
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {victim_tag_q, index_q};
                if (mem_ack_i) state_d = S_FILL;
            end
            S_FILL: begin
                lru_index_o = index_q;
                mem_req_o   = 1'b1;
                mem_addr_o  = {tag_q, index_q};
                if (mem_ack_i) state_d = S_UPDATE;
            end
            S_UPDATE: begin
                tag_we_o       = 1'b1;
                tag_o          = tag_q;
                tag_rd_way_o   = victim_q;
                lru_write_en_o = 1'b1;
                lru_set_o      = victim_q;
                lru_index_o    = index_q;
                state_d        = S_DONE;
            end
            S_DONE: begin
                lru_index_o = index_q;
                fill_done_o = 1'b1;
                fill_way_o  = victim_q;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef MISS_HANDLER_STATS_EN
    logic [15:0] miss_count_q, wb_count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            miss_count_q <= '0;
            wb_count_q   <= '0;
        end else begin
            if (miss_accept && miss_count_q != 16'hFFFF) miss_count_q <= miss_count_q + 16'd1;
            if (state_q == S_TAG_RD && state_d == S_WB && wb_count_q != 16'hFFFF)
                wb_count_q <= wb_count_q + 16'd1;
        end
    end

    assign miss_count_o = miss_count_q;
    assign wb_count_o   = wb_count_q;
`endif

endmodule
